node_inject_tx: RTL and testbench
=================================

// Module: node_inject_tx
// PURPOSE
//  Network-interface transmitter on the local (port 4) input of a node router.
//  Accepts {destination, payload} requests from the neuron core and buffers them in a FIFO.
//  Forms router stream words with the destination address in the top net_width bits.
//  Presents them with a valid/ready handshake to the router arbiter.
//  Self-addressed requests bypass the router on a local loopback output.
// PARAMETERS
//  net_width     4    destination address width; x = dest[nw_half-1:0], y = dest[nw_full-1:nw_half]
//  stream_width  144  router stream word width; payload width PW = stream_width-net_width
//  nw_full       4    address bits per layer
//  nw_half       2    x-field width within a layer
//  self_x        0    this node's x coordinate
//  self_y        0    this node's y coordinate
//  fifo_depth    4    request FIFO entries; power of 2, >= 2
// PORTS
//  clk         in   1                    clock, rising edge
//  rst         in   1                    asynchronous reset, active-high
//  core_valid  in   1                    core request valid
//  core_ready  out  1                    FIFO can accept; equals !full
//  core_dest   in   net_width            destination address
//  core_data   in   PW                   payload
//  tx_stream   out  stream_width         {dest, payload} to router local input
//  tx_valid    out  1                    tx_stream holds a word
//  tx_ready    in   1                    router grant; transfer when tx_valid & tx_ready
//  loop_valid  out  1                    one-cycle pulse, self-addressed payload delivered
//  loop_data   out  PW                   loopback payload
//  fifo_count  out  $clog2(fifo_depth)+1 occupied FIFO entries
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - core_ready=1; tx_valid=0; tx_stream=0; loop_valid=0; loop_data=0; fifo_count=0.
//   - Pointers are cleared. The FIFO and output-register contents are discarded, including a word held mid-handshake.
//  Push: on core_valid & core_ready, write {core_dest, core_data} at the write pointer.
//   - When full, core_ready=0 and no push occurs, even if a pop happens in the same cycle.
//  Output stage FSM, states EMPTY / HOLD:
//   - EMPTY: tx_valid=0. If FIFO is non-empty, pop the head and go to HOLD.
//   - HOLD: tx_valid=1. tx_stream is stable until accepted.
//     - tx_ready=1: transfer; pop the next head if present (stay HOLD, zero bubble), else go to EMPTY.
//     - tx_ready=0: stay HOLD; stall.
//  Self-address check is done at pop time:
//   - A head with dest x==self_x and y==self_y is never loaded into tx_stream.
//   - It asserts loop_valid for one cycle with loop_data = its payload; loop_data holds its value afterwards.
//   - loop has no backpressure; at most one pop (loop or tx) per cycle.
//  Latency: push into an empty FIFO with EMPTY output gives tx_valid (or loop_valid) on the next cycle.
//  Ordering: strict FIFO order across tx and loop outputs.
//  fifo_count = pushes - pops, wraps correctly via (log2+1)-bit pointers.
//   - Full when count==fifo_depth, empty when 0.
//  Simultaneous push and pop: both take effect; count unchanged.
// CONFIGURATION
//  TX_STALL_CNT_EN defined: adds output stall_cnt[15:0], reset 0.
//   - Increments on every cycle with tx_valid & !tx_ready, saturating at 16'hFFFF.
//   - Never clears except on rst.
//  TX_STALL_CNT_EN undefined: the port and counter do not exist; behaviour otherwise identical.
// TESTING
//  - Reset: rst=1 mid-HOLD with 3 entries queued -> same cycle: tx_valid=0, fifo_count=0, core_ready=1.
//  - Single send: dest=4'b0110, data=1, tx_ready=1, self=(0,0) -> next cycle tx_stream={4'h6,140'd1}, tx_valid=1; transfer, then EMPTY.
//  - Backpressure: push 5 words with tx_ready=0, depth 4 -> 1 held in HOLD + 4 queued; 6th push refused (core_ready=0); order preserved when tx_ready=1.
//  - Loopback: dest x=0,y=0, self=(0,0), data=140'hA5 -> loop_valid one-cycle pulse with loop_data=hA5; tx_valid stays 0.
//  - Back-to-back: tx_ready held 1, core pushes every cycle -> one transfer per cycle, no bubbles, fifo_count constant.
//  - TX_STALL_CNT_EN: hold tx_ready=0 for 70000 cycles with tx_valid=1 -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/node_inject_tx.sv
// node_inject_tx: local-port transmitter of a node router.
// Core requests {dest, payload} are queued in a small FIFO. The output stage
// presents them to the router with valid/ready. Requests addressed to this
// node skip the router and leave on a one-cycle loopback pulse instead.
// The FIFO head can be taken in the same cycle a word is pushed into an empty
// FIFO, which gives one cycle from push to tx_valid/loop_valid.
// Optional build macro: TX_STALL_CNT_EN adds a saturating stall counter port.
module node_inject_tx #(
  parameter int net_width    = 4,
  parameter int stream_width = 144,
  parameter int nw_full      = 4,
  parameter int nw_half      = 2,
  parameter int self_x       = 0,
  parameter int self_y       = 0,
  parameter int fifo_depth   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 core_valid,
  output logic                                 core_ready,
  input  logic [net_width-1:0]                 core_dest,
  input  logic [stream_width-net_width-1:0]    core_data,
  output logic [stream_width-1:0]              tx_stream,
  output logic                                 tx_valid,
  input  logic                                 tx_ready,
  output logic                                 loop_valid,
  output logic [stream_width-net_width-1:0]    loop_data,
`ifdef TX_STALL_CNT_EN
  output logic [15:0]                          stall_cnt,
`endif
  output logic [$clog2(fifo_depth):0]          fifo_count
);

  localparam int PW = stream_width - net_width;
  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  logic [stream_width-1:0] mem_q [fifo_depth];
  logic [CW-1:0]           wr_ptr_q;
  logic [CW-1:0]           rd_ptr_q;
  logic [CW-1:0]           count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    head_avail;
  logic [stream_width-1:0] head_word;
  logic [net_width-1:0]    head_dest;
  logic                    head_self;

  state_t                  state_q;
  state_t                  state_d;
  logic                    pop;
  logic                    load_tx;
  logic                    load_loop;

  logic [stream_width-1:0] tx_stream_q;
  logic                    loop_valid_q;
  logic [PW-1:0]           loop_data_q;

  // Occupancy from the extra-MSB pointers; full blocks a push even if a pop
  // happens in the same cycle.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (count == CW'(fifo_depth));
  assign fifo_empty = (count == '0);
  assign push       = core_valid & ~fifo_full;

  // Head of the queue: the incoming word when the FIFO is empty, so a fresh
  // request reaches the output stage without waiting a cycle.
  assign head_avail = ~fifo_empty | push;
  assign head_word  = fifo_empty ? {core_dest, core_data} : mem_q[rd_ptr_q[AW-1:0]];
  assign head_dest  = head_word[stream_width-1 -: net_width];
  assign head_self  = (head_dest[nw_half-1:0]       == nw_half'(self_x)) &&
                      (head_dest[nw_full-1:nw_half] == (nw_full - nw_half)'(self_y));

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {core_dest, core_data};
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output stage next state and pop decision: a pop happens whenever the
  // stage is free (EMPTY) or its word is being accepted this cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (head_avail) begin
          pop     = 1'b1;
          state_d = head_self ? EMPTY : HOLD;
        end
      end
      HOLD: begin
        if (tx_ready) begin
          if (head_avail) begin
            pop     = 1'b1;
            state_d = head_self ? EMPTY : HOLD;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    load_tx   = pop & ~head_self;
    load_loop = pop &  head_self;
  end

  // Router-facing word register; held stable while the router stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_stream_q <= '0;
    end else if (load_tx) begin
      tx_stream_q <= head_word;
    end
  end

  // Loopback pulse and sticky payload for self-addressed requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_valid_q <= 1'b0;
      loop_data_q  <= '0;
    end else begin
      loop_valid_q <= load_loop;
      if (load_loop) loop_data_q <= head_word[PW-1:0];
    end
  end

`ifdef TX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where the router withholds its grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == HOLD) && !tx_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign core_ready = ~fifo_full;
  assign tx_stream  = tx_stream_q;
  assign tx_valid   = (state_q == HOLD);
  assign loop_valid = loop_valid_q;
  assign loop_data  = loop_data_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_node_inject_tx.sv
`define CHK(nm, a, e) chk(nm, 256'(a), 256'(e))

module tb_node_inject_tx;
  localparam int NW = 4;
  localparam int SW = 144;
  localparam int PW = SW - NW;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_valid;
  logic          core_ready;
  logic [NW-1:0] core_dest;
  logic [PW-1:0] core_data;
  logic [SW-1:0] tx_stream;
  logic          tx_valid;
  logic          tx_ready;
  logic          loop_valid;
  logic [PW-1:0] loop_data;
  logic [2:0]    fifo_count;
`ifdef TX_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  node_inject_tx #(
    .net_width(NW), .stream_width(SW), .nw_full(4), .nw_half(2),
    .self_x(0), .self_y(0), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_dest(core_dest), .core_data(core_data),
    .tx_stream(tx_stream), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .loop_valid(loop_valid), .loop_data(loop_data),
`ifdef TX_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic is_self(input logic [SW-1:0] w);
    return (w[SW-1 -: NW] == 4'h0);
  endfunction

  function automatic logic [PW-1:0] rnd_pw();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  logic [SW-1:0] mq[$];
  logic          m_hold_v;
  logic [SW-1:0] m_hold_w;
  logic          m_loop_v;
  logic [PW-1:0] m_loop_d;
  logic [SW-1:0] m_w;
  logic [15:0]   m_stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_hold_v = 1'b0;
      m_hold_w = '0;
      m_loop_v = 1'b0;
      m_loop_d = '0;
      m_stall  = '0;
    end else begin
      if (m_hold_v && !tx_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      m_loop_v = 1'b0;
      if (core_valid && mq.size() < DEPTH) mq.push_back({core_dest, core_data});
      if (!m_hold_v || tx_ready) begin
        m_hold_v = 1'b0;
        if (mq.size() > 0) begin
          m_w = mq.pop_front();
          if (is_self(m_w)) begin
            m_loop_v = 1'b1;
            m_loop_d = m_w[PW-1:0];
          end else begin
            m_hold_v = 1'b1;
            m_hold_w = m_w;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (tx_valid !== m_hold_v) begin
        failures++;
        $display("FAIL m_tx_valid actual=%0h required=%0h", tx_valid, m_hold_v);
      end
      if (m_hold_v) begin
        checks++;
        if (tx_stream !== m_hold_w) begin
          failures++;
          $display("FAIL m_tx_stream actual=%0h required=%0h", tx_stream, m_hold_w);
        end
      end
      checks++;
      if (loop_valid !== m_loop_v) begin
        failures++;
        $display("FAIL m_loop_valid actual=%0h required=%0h", loop_valid, m_loop_v);
      end
      checks++;
      if (loop_data !== m_loop_d) begin
        failures++;
        $display("FAIL m_loop_data actual=%0h required=%0h", loop_data, m_loop_d);
      end
      checks++;
      if (fifo_count !== 3'(mq.size())) begin
        failures++;
        $display("FAIL m_fifo_count actual=%0h required=%0h", fifo_count, mq.size());
      end
      checks++;
      if (core_ready !== (mq.size() < DEPTH)) begin
        failures++;
        $display("FAIL m_core_ready actual=%0h required=%0h", core_ready, (mq.size() < DEPTH));
      end
`ifdef TX_STALL_CNT_EN
      checks++;
      if (stall_cnt !== m_stall) begin
        failures++;
        $display("FAIL m_stall_cnt actual=%0h required=%0h", stall_cnt, m_stall);
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [NW-1:0] d, input logic [PW-1:0] p);
    core_valid = v;
    core_dest  = d;
    core_data  = p;
  endtask

  logic [SW-1:0] rec[$];
  logic [NW-1:0] bp_dest [5];
  logic [NW-1:0] rd;

  initial begin
    bp_dest = '{4'h5, 4'h6, 4'h9, 4'hA, 4'hF};
    rst = 1'b1;
    tx_ready = 1'b0;
    drive(1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    `CHK("rst_core_ready", core_ready, 1'b1);
    `CHK("rst_tx_valid", tx_valid, 1'b0);
    `CHK("rst_tx_stream", tx_stream, 144'd0);
    `CHK("rst_loop_valid", loop_valid, 1'b0);
    `CHK("rst_loop_data", loop_data, 140'd0);
    `CHK("rst_fifo_count", fifo_count, 3'd0);
    step();

    tx_ready = 1'b1;
    drive(1'b1, 4'b0110, 140'd1);
    step();
    drive(1'b0, '0, '0);
    `CHK("single_tx_valid", tx_valid, 1'b1);
    `CHK("single_tx_stream", tx_stream, {4'h6, 140'd1});
    step();
    `CHK("single_empty_after", tx_valid, 1'b0);

    drive(1'b1, 4'h0, 140'hA5);
    step();
    drive(1'b0, '0, '0);
    `CHK("loop_pulse", loop_valid, 1'b1);
    `CHK("loop_data", loop_data, 140'hA5);
    `CHK("loop_no_tx", tx_valid, 1'b0);
    step();
    `CHK("loop_pulse_end", loop_valid, 1'b0);
    `CHK("loop_data_held", loop_data, 140'hA5);

    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bp_dest[i], 140'(i + 16));
      `CHK("bp_ready", core_ready, 1'b1);
      step();
    end
    drive(1'b1, 4'h7, 140'h66);
    `CHK("bp_full_refused", core_ready, 1'b0);
    `CHK("bp_count", fifo_count, 3'd4);
    `CHK("bp_holding", tx_valid, 1'b1);
    step();
    drive(1'b0, '0, '0);
    tx_ready = 1'b1;
    rec.delete();
    for (int k = 0; k < 10; k++) begin
      if (tx_valid) rec.push_back(tx_stream);
      step();
    end
    `CHK("bp_num_transfers", rec.size(), 5);
    for (int i = 0; i < 5 && i < rec.size(); i++)
      `CHK("bp_order", rec[i], {bp_dest[i], 140'(i + 16)});

    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h9, 140'(i + 100));
      step();
    end
    drive(1'b0, '0, '0);
    `CHK("pre_rst_count", fifo_count, 3'd3);
    #1 rst = 1'b1;
    #1;
    `CHK("async_rst_tx_valid", tx_valid, 1'b0);
    `CHK("async_rst_count", fifo_count, 3'd0);
    `CHK("async_rst_ready", core_ready, 1'b1);
    step();
    rst = 1'b0;
    step();

    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd = 4'($urandom());
      drive(1'b1, {rd[3:2], 2'b01}, rnd_pw());
      step();
      `CHK("b2b_tx_valid", tx_valid, 1'b1);
      `CHK("b2b_count", fifo_count, 3'd0);
    end
    drive(1'b0, '0, '0);
    step();

    for (int c = 0; c < 3000; c++) begin
      rd = ($urandom() % 4 == 0) ? 4'h0 : 4'($urandom());
      drive(($urandom() % 4) != 0, rd, rnd_pw());
      tx_ready = (c % 200 < 40) ? 1'b0 : (($urandom() % 3) != 0);
      if (c == 1500) begin
        #1 rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    drive(1'b0, '0, '0);

`ifdef TX_STALL_CNT_EN
    tx_ready = 1'b0;
    drive(1'b1, 4'h5, 140'h1);
    step();
    drive(1'b0, '0, '0);
    repeat (70000) step();
    `CHK("stall_saturated", stall_cnt, 16'hFFFF);
    tx_ready = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
